// File: rtl/dff_reg_rr_arbiter.sv
// rtl/dff_reg_rr_arbiter.sv - round-robin ownership arbiter for one shared WIDTH-bit register
module dff_reg_rr_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           wr_en,
   input  logic [NREQ*WIDTH-1:0]     d_in,
   output logic [NREQ-1:0]           gnt,
   output logic                      gnt_valid,
   output logic [WIDTH-1:0]          q,
   output logic [$clog2(NREQ)-1:0]   q_owner,
   output logic                      wr_ack
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [IW-1:0]   owner_inc;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [NREQ-1:0] others;
   logic [NREQ-1:0] gnt_nxt;

   // First set bit of r, scanning upward from start with wrap-around.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
      logic [IW-1:0] pick;
      logic [IW-1:0] idx;
      logic          found;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(start) + k) % NREQ);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      others    = req & ~(NREQ'(1) << owner);
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = OWNED;
               owner_nxt = rr_pick(req, ptr);
               cnt_nxt   = '0;
            end
         end
         OWNED: begin
            if (!req[owner]) begin
               cnt_nxt = '0;
               if (|others) begin
                  owner_nxt = rr_pick(others, owner_inc);
               end else begin
                  state_nxt = IDLE;
                  ptr_nxt   = owner_inc;
               end
            end else if ((cnt == CNT_MAX) && (|others)) begin
               owner_nxt = rr_pick(others, owner_inc);
               cnt_nxt   = '0;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      gnt_nxt = (state_nxt == OWNED) ? (NREQ'(1) << owner_nxt) : '0;
   end

   // Writes are decided by the grant held before the edge, so an outgoing owner still lands its data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= '0;
         ptr     <= '0;
         cnt     <= '0;
         gnt     <= '0;
         q       <= '0;
         q_owner <= '0;
         wr_ack  <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         if ((state == OWNED) && wr_en[owner]) begin
            q       <= d_in[int'(owner)*WIDTH +: WIDTH];
            q_owner <= owner;
            wr_ack  <= 1'b1;
         end else begin
            wr_ack  <= 1'b0;
         end
      end
   end

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_dff_reg_rr_arbiter.sv
// tb/tb_dff_reg_rr_arbiter.sv - self-checking bench for dff_reg_rr_arbiter
module tb_dff_reg_rr_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int H = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   wr_en;
   logic [N*W-1:0] d_in;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [W-1:0]   q;
   logic [1:0]     q_owner;
   logic           wr_ack;

   int checks = 0;
   int errors = 0;

   dff_reg_rr_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .d_in(d_in),
      .gnt(gnt), .gnt_valid(gnt_valid), .q(q), .q_owner(q_owner), .wr_ack(wr_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = idle), cycles held so far, idle scan start.
   int         m_own  = -1;
   int         m_ten  = 0;
   int         m_ptr  = 0;
   logic [7:0] m_q    = 8'h00;
   int         m_qown = 0;
   bit         m_ack  = 1'b0;
   bit         m_live = 1'b0;

   function automatic int pick(input logic [N-1:0] r, input int start);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (start + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      logic [N-1:0] oth;
      if (rst) begin
         m_own = -1; m_ten = 0; m_ptr = 0; m_q = 8'h00; m_qown = 0; m_ack = 1'b0; m_live = 1'b1;
      end else begin
         if (m_own >= 0 && wr_en[m_own]) begin
            m_q = d_in[m_own*W +: W]; m_qown = m_own; m_ack = 1'b1;
         end else begin
            m_ack = 1'b0;
         end
         if (m_own < 0) begin
            if (req != 0) begin m_own = pick(req, m_ptr); m_ten = 1; end
         end else begin
            oth = req;
            oth[m_own] = 1'b0;
            if (!req[m_own]) begin
               if (oth != 0) begin m_own = pick(oth, (m_own + 1) % N); m_ten = 1; end
               else begin m_ptr = (m_own + 1) % N; m_own = -1; m_ten = 0; end
            end else if (oth != 0 && m_ten >= H) begin
               m_own = pick(oth, (m_own + 1) % N); m_ten = 1;
            end else begin
               m_ten++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] eg;
      if (m_live) begin
         eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
         chk("model_gnt", 32'(gnt), 32'(eg));
         chk("model_gnt_valid", 32'(gnt_valid), 32'(m_own >= 0));
         chk("model_q", 32'(q), 32'(m_q));
         chk("model_q_owner", 32'(q_owner), 32'(m_qown));
         chk("model_wr_ack", 32'(wr_ack), 32'(m_ack));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; wr_en = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'b1111; wr_en = 4'b1111; d_in = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_gnt", 32'(gnt), 32'h0);
         chk("reset_q", 32'(q), 32'h0);
         chk("reset_q_owner", 32'(q_owner), 32'h0);
         chk("reset_wr_ack", 32'(wr_ack), 32'h0);
      end
      rst = 1'b0; req = '0; wr_en = '0;
      tick();

      // single requester with a write
      req = 4'b0100;
      tick();
      chk("single_gnt", 32'(gnt), 32'h4);
      wr_en = 4'b0100; d_in[2*W +: W] = 8'hA5;
      tick();
      chk("single_q", 32'(q), 32'hA5);
      chk("single_q_owner", 32'(q_owner), 32'h2);
      chk("single_ack", 32'(wr_ack), 32'h1);
      wr_en = '0;
      tick();
      chk("single_ack_drop", 32'(wr_ack), 32'h0);
      req = '0;
      tick();
      chk("single_release", 32'(gnt), 32'h0);

      // full contention from reset: four-cycle tenures, 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("rr_seq", 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
      end

      // non-owner write strobe is ignored
      do_reset();
      req = 4'b0010;
      tick();
      wr_en = 4'b1000; d_in[3*W +: W] = 8'h3C;
      tick();
      chk("ign_q", 32'(q), 32'h0);
      chk("ign_ack", 32'(wr_ack), 32'h0);
      wr_en = '0;

      // handover: outgoing write lands, incoming write ignored until re-asserted
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'b0101;
      tick();
      req = 4'b0100; wr_en = 4'b0101; d_in[0 +: W] = 8'h11; d_in[2*W +: W] = 8'h22;
      tick();
      chk("ho_q", 32'(q), 32'h11);
      chk("ho_gnt", 32'(gnt), 32'h4);
      wr_en = '0;
      tick();
      chk("ho_q_hold", 32'(q), 32'h11);
      wr_en = 4'b0100;
      tick();
      chk("ho_q_new", 32'(q), 32'h22);
      chk("ho_q_owner", 32'(q_owner), 32'h2);
      wr_en = '0;

      // reset mid-tenure, then pointer restarts at 0
      do_reset();
      req = 4'b1000;
      tick();
      wr_en = 4'b1000; d_in[3*W +: W] = 8'h77;
      tick();
      wr_en = '0;
      rst = 1'b1;
      tick();
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_q", 32'(q), 32'h0);
      rst = 1'b0; req = 4'b1001;
      tick();
      chk("ptr_restart", 32'(gnt), 32'h1);

      // lone requester keeps the grant past HOLD_MAX
      req = 4'b0010;
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("lone_gnt", 32'(gnt), 32'h2);
      end

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            if (req[i]) req[i] = ($urandom_range(0, 5) != 0);
            else        req[i] = ($urandom_range(0, 3) == 0);
         end
         wr_en = N'($urandom);
         d_in  = $urandom;
         tick();
      end
      rst = 1'b0; req = '0; wr_en = '0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dff_reg_rr_arbiter.md
Name: dff_reg_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit positive-edge register among NREQ requesters.
- Only the current grant holder may write the register. Tenure is capped at HOLD_MAX cycles whenever another requester is waiting.
- Sits in front of the shared flip-flop bank in the sequential_logic library. It sequences ownership and write strobes for that bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register.
- HOLD_MAX, 4, maximum consecutive grant cycles for one requester while any other req is pending (>=1).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request vector; bit i is held high by requester i until it is done.
- wr_en  input  NREQ  write strobe per requester; honoured only for the granted requester.
- d_in  input  NREQ*WIDTH  packed write data; slice i is [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered; all-zero when idle.
- gnt_valid  output  1  OR of gnt.
- q  output  WIDTH  shared register contents.
- q_owner  output  clog2(NREQ)  index of the last requester that wrote q.
- wr_ack  output  1  registered; high one cycle after an accepted write.

Behaviour:
- Reset (rst=1 at posedge): gnt=0, gnt_valid=0, q=0, q_owner=0, wr_ack=0, hold counter=0, RR pointer=0. Reset overrides everything, including an in-progress write or tenure.
- States:
  - IDLE: gnt=0.
  - OWNED: exactly one gnt bit set.
- IDLE -> OWNED:
  - Triggered at the first posedge where req!=0.
  - Winner is the first set req bit scanning from the RR pointer upward with wrap-around (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - Grant latency is 1 cycle: req sampled at edge t, gnt visible after edge t.
- OWNED, owner i, at each posedge:
  - req[i]=0 and other req pending: grant moves directly to the next winner, scanning from i+1. No idle bubble.
  - req[i]=0 and no other req: go to IDLE. Pointer = i+1 mod NREQ.
  - req[i]=1, hold counter = HOLD_MAX-1, and another req pending: forced rotation to the next winner, scanning from i+1.
  - req[i]=1, otherwise: keep grant; hold counter +1, saturating at HOLD_MAX-1.
  - Hold counter clears to 0 on every grant change.
- Lone requester: with no other req pending, the owner keeps the grant indefinitely; the counter saturates and does not rotate.
- Write rule:
  - At a posedge where gnt[i]=1 and wr_en[i]=1: q <= d_in slice i, q_owner <= i, wr_ack <= 1 for the next cycle.
  - Otherwise q holds and wr_ack <= 0.
  - wr_en bits of non-granted requesters are ignored (no write, no ack).
- Handover edge:
  - The write decision uses the grant valid before the edge.
  - An outgoing owner's wr_en at the handover edge is accepted.
  - The incoming owner's wr_en at that edge is ignored.
- Simultaneous requests: exactly one grant. Ties are resolved purely by RR scan order.
- gnt is never multi-hot. There are no combinational paths from req or wr_en to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111, wr_en=4'b1111 -> gnt=0, q=8'h00, q_owner=0, wr_ack=0 throughout.
- Single request:
  - req=4'b0100 at edge t -> gnt=4'b0100 after edge t.
  - wr_en[2]=1, d_in slice 2 = 8'hA5 -> q=8'hA5, q_owner=2, wr_ack pulses 1 cycle.
  - Drop req -> gnt=0 next cycle.
- Round-robin from reset: req=4'b1111 held continuously, no writes -> grant sequence 0,1,2,3,0.
  - Each tenure is exactly 4 cycles (HOLD_MAX), with no idle cycles between tenures.
- Ignored write: owner=1; wr_en[3]=1 with d_in slice 3 = 8'h3C, wr_en[1]=0 -> q unchanged, wr_ack=0.
- Handover:
  - Owner 0 drops req while req[2]=1, with wr_en[0]=1 (8'h11) and wr_en[2]=1 (8'h22) at the same edge -> q=8'h11, gnt becomes 4'b0100.
  - 8'h22 is written only when wr_en[2] is re-asserted on a later cycle.
- Mid-tenure reset and lone requester:
  - Owner 3 mid-tenure, assert rst one cycle -> gnt=0, q=0; pointer restarts at 0, so req=4'b1001 grants requester 0 first.
  - req=4'b0010 alone for 10 cycles -> gnt stays 4'b0010 for all 10 cycles (no forced rotation).
